ppt_reg_bank: RTL and testbench

//   Parametrised byte-addressed register bank between the I2C slave and the PPT

---
 rtl/ppt_reg_bank.sv | 142 ++++++++++++++
 tb/tb_ppt_reg_bank.sv | 244 ++++++++++++++++++++++++
 2 files changed

// File: rtl/ppt_reg_bank.sv
// ---------------------------------------------------------------------------
// ppt_reg_bank
//   Byte-addressed register bank between the I2C slave and the PPT controller.
//   It holds RW configuration registers that take their reset defaults from
//   RESET_VALUES. It has a read-only status window: a read of RO_BASE
//   snapshots every status slice, so multi-byte status reads stay coherent.
//   It also has a write-1-to-clear sticky event register and a masked,
//   registered interrupt.
//
// Ports
//   clk, rstn      system clock (rising edge), async active-low reset
//   address        register address from the I2C side
//   data_in        write data
//   write_enable   one-cycle write strobe
//   read_enable    one-cycle read strobe
//   data_out       registered read data, holds between reads
//   data_valid     one-cycle pulse, data_out valid
//   wr_error       one-cycle pulse, a write targeted the read-only window
//   status_in      live status slices from the PPT core
//   event_in       per-bit set pulses for the sticky register
//   cfg            flattened register image towards the PPT core
//   irq            registered |(sticky & mask)
// ---------------------------------------------------------------------------
module ppt_reg_bank #(
    parameter int ADDR_W      = 4,
    parameter int DATA_W      = 8,
    parameter int RO_BASE     = 8,
    parameter int RO_COUNT    = 2,
    parameter int STICKY_ADDR = 10,
    parameter int MASK_ADDR   = 11,
    parameter logic [(2**ADDR_W)*DATA_W-1:0] RESET_VALUES =
        128'h0000_0000_0000_0000_0000_1000_0100_8009
) (
    input  logic                          clk,
    input  logic                          rstn,
    input  logic [ADDR_W-1:0]             address,
    input  logic [DATA_W-1:0]             data_in,
    input  logic                          write_enable,
    input  logic                          read_enable,
    output logic [DATA_W-1:0]             data_out,
    output logic                          data_valid,
    output logic                          wr_error,
    input  logic [RO_COUNT*DATA_W-1:0]    status_in,
    input  logic [DATA_W-1:0]             event_in,
    output logic [(2**ADDR_W)*DATA_W-1:0] cfg,
    output logic                          irq
);

    localparam int DEPTH = 2**ADDR_W;

    // Illegal parameter combinations stop elaboration.
    if (RO_COUNT < 1) begin : g_err_ro_count
        $error("ppt_reg_bank: RO_COUNT must be at least 1");
    end
    if (RO_BASE + RO_COUNT > DEPTH) begin : g_err_ro_range
        $error("ppt_reg_bank: read-only window extends past DEPTH");
    end
    if (STICKY_ADDR >= DEPTH || MASK_ADDR >= DEPTH) begin : g_err_addr_range
        $error("ppt_reg_bank: STICKY_ADDR/MASK_ADDR out of range");
    end
    if (STICKY_ADDR >= RO_BASE && STICKY_ADDR < RO_BASE + RO_COUNT) begin : g_err_sticky
        $error("ppt_reg_bank: STICKY_ADDR inside read-only window");
    end
    if (MASK_ADDR >= RO_BASE && MASK_ADDR < RO_BASE + RO_COUNT) begin : g_err_mask
        $error("ppt_reg_bank: MASK_ADDR inside read-only window");
    end

    function automatic logic in_ro(input int a);
        return (a >= RO_BASE) && (a < RO_BASE + RO_COUNT);
    endfunction

    // Read-only slots keep a constant zero in regs; their value comes from
    // status_in or the snapshot instead.
    logic [DATA_W-1:0]          regs [DEPTH];
    logic [RO_COUNT*DATA_W-1:0] shadow;
    logic                       addr_ro;
    logic [ADDR_W-1:0]          ro_idx;

    assign addr_ro = in_ro(int'(address));
    assign ro_idx  = address - ADDR_W'(RO_BASE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == STICKY_ADDR || in_ro(i))
                    regs[i] <= '0;
                else
                    regs[i] <= RESET_VALUES[i*DATA_W +: DATA_W];
            end
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                if (i == STICKY_ADDR) begin
                    // New events are ORed in after the clear, so a set wins
                    // over a clear on the same bit.
                    if (write_enable && address == ADDR_W'(i))
                        regs[i] <= (regs[i] & ~data_in) | event_in;
                    else
                        regs[i] <= regs[i] | event_in;
                end else if (!in_ro(i) && write_enable && address == ADDR_W'(i)) begin
                    regs[i] <= data_in;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            data_out   <= '0;
            data_valid <= 1'b0;
            wr_error   <= 1'b0;
            irq        <= 1'b0;
            shadow     <= '0;
        end else begin
            data_valid <= read_enable;
            wr_error   <= write_enable && addr_ro;
            irq        <= |(regs[STICKY_ADDR] & regs[MASK_ADDR]);
            if (read_enable) begin
                if (addr_ro) begin
                    // A read of the first status byte freezes all slices, so
                    // later bytes match the one just returned.
                    if (ro_idx == '0) begin
                        data_out <= status_in[DATA_W-1:0];
                        shadow   <= status_in;
                    end else begin
                        data_out <= shadow[int'(ro_idx)*DATA_W +: DATA_W];
                    end
                end else begin
                    data_out <= regs[address];
                end
            end
        end
    end

    for (genvar g = 0; g < DEPTH; g++) begin : g_cfg
        if (g >= RO_BASE && g < RO_BASE + RO_COUNT) begin : g_ro
            assign cfg[g*DATA_W +: DATA_W] = status_in[(g-RO_BASE)*DATA_W +: DATA_W];
        end else begin : g_rw
            assign cfg[g*DATA_W +: DATA_W] = regs[g];
        end
    end

endmodule

// File: tb/tb_ppt_reg_bank.sv
// ---------------------------------------------------------------------------
// tb_ppt_reg_bank
//   Checks ppt_reg_bank against a behavioural model of the register map.
//   Directed scenarios cover reset, RW access, read-only protection, status
//   snapshots, W1C and irq. A randomized phase follows.
// ---------------------------------------------------------------------------
module tb_ppt_reg_bank;

    localparam int STK = 10;
    localparam int MSK = 11;
    localparam logic [127:0] RV = 128'h0000_0000_0000_0000_0000_1000_0100_8009;

    logic         clk;
    logic         rstn;
    logic [3:0]   address;
    logic [7:0]   data_in;
    logic         write_enable;
    logic         read_enable;
    logic [7:0]   data_out;
    logic         data_valid;
    logic         wr_error;
    logic [15:0]  status_in;
    logic [7:0]   event_in;
    logic [127:0] cfg;
    logic         irq;

    ppt_reg_bank #(
        .ADDR_W(4), .DATA_W(8), .RO_BASE(8), .RO_COUNT(2),
        .STICKY_ADDR(STK), .MASK_ADDR(MSK), .RESET_VALUES(RV)
    ) dut (
        .clk(clk), .rstn(rstn), .address(address), .data_in(data_in),
        .write_enable(write_enable), .read_enable(read_enable),
        .data_out(data_out), .data_valid(data_valid), .wr_error(wr_error),
        .status_in(status_in), .event_in(event_in), .cfg(cfg), .irq(irq)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // behavioural model state
    logic [7:0]  m_reg [16];
    logic [7:0]  m_sticky;
    logic [15:0] m_shadow;
    logic [7:0]  e_dout;
    logic        e_valid, e_wrerr, e_irq;

    int errors = 0;
    int checks = 0;

    function automatic logic is_ro(input logic [3:0] a);
        return (a == 4'd8) || (a == 4'd9);
    endfunction

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic model_reset();
        for (int i = 0; i < 16; i++) m_reg[i] = RV[i*8 +: 8];
        m_sticky = 8'h00;
        m_shadow = 16'h0000;
        e_dout   = 8'h00;
        e_valid  = 1'b0;
        e_wrerr  = 1'b0;
        e_irq    = 1'b0;
    endtask

    function automatic logic [127:0] exp_cfg();
        logic [127:0] c;
        for (int i = 0; i < 16; i++) begin
            if (i == 8)        c[i*8 +: 8] = status_in[7:0];
            else if (i == 9)   c[i*8 +: 8] = status_in[15:8];
            else if (i == STK) c[i*8 +: 8] = m_sticky;
            else               c[i*8 +: 8] = m_reg[i];
        end
        return c;
    endfunction

    // Apply one rising edge to the model. All reads use pre-edge values.
    task automatic model_edge();
        logic [7:0] old_sticky;
        logic [7:0] old_mask;
        if (!rstn) begin
            model_reset();
            return;
        end
        old_sticky = m_sticky;
        old_mask   = m_reg[MSK];
        e_irq   = |(old_sticky & old_mask);
        e_valid = read_enable;
        e_wrerr = write_enable && is_ro(address);
        if (read_enable) begin
            if (address == 4'd8) begin
                e_dout   = status_in[7:0];
                m_shadow = status_in;
            end else if (address == 4'd9) begin
                e_dout = m_shadow[15:8];
            end else if (address == 4'(STK)) begin
                e_dout = old_sticky;
            end else begin
                e_dout = m_reg[address];
            end
        end
        if (write_enable && address == 4'(STK))
            m_sticky = (old_sticky & ~data_in) | event_in;
        else
            m_sticky = old_sticky | event_in;
        if (write_enable && !is_ro(address) && address != 4'(STK))
            m_reg[address] = data_in;
    endtask

    task automatic compare_all();
        chk("data_valid", data_valid, e_valid);
        chk("data_out",   data_out,   e_dout);
        chk("wr_error",   wr_error,   e_wrerr);
        chk("irq",        irq,        e_irq);
        chk("cfg",        cfg,        exp_cfg());
    endtask

    task automatic cyc(input logic we, input logic re, input logic [3:0] a,
                       input logic [7:0] d, input logic [7:0] ev);
        write_enable = we;
        read_enable  = re;
        address      = a;
        data_in      = d;
        event_in     = ev;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        compare_all();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rstn = 1'b0;
        write_enable = 1'b0;
        read_enable  = 1'b0;
        address   = 4'd0;
        data_in   = 8'h00;
        event_in  = 8'h00;
        status_in = 16'h0000;
        model_reset();
        repeat (2) @(negedge clk);
        compare_all();
        chk("t1_cfg_init", cfg, 128'h0000_0000_0000_0000_0000_1000_0100_8009);
        rstn = 1'b1;

        // T1: traffic, then reset asserted mid-stream with a write in flight
        cyc(1'b1, 1'b0, 4'd0, 8'hEE, 8'h00);
        cyc(1'b0, 1'b1, 4'd0, 8'h00, 8'h03);
        rstn = 1'b0;
        #1;
        model_reset();
        compare_all();
        chk("t1_cfg_rst", cfg, 128'h0000_0000_0000_0000_0000_1000_0100_8009);
        chk("t1_dout_rst", data_out, 8'h00);
        cyc(1'b1, 1'b1, 4'd3, 8'h77, 8'h01);
        chk("t1_irq_rst", irq, 1'b0);
        rstn = 1'b1;
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("t1_dout_post", data_out, 8'h00);
        chk("t1_irq_post", irq, 1'b0);
        chk("t1_reg3", cfg[31:24], 8'h01);

        // T2: RW access and same-cycle read+write
        cyc(1'b1, 1'b0, 4'd1, 8'h5A, 8'h00);
        cyc(1'b0, 1'b1, 4'd1, 8'h00, 8'h00);
        chk("t2_rd", data_out, 8'h5A);
        chk("t2_valid", data_valid, 1'b1);
        cyc(1'b1, 1'b1, 4'd1, 8'hA5, 8'h00);
        chk("t2_rdwr_old", data_out, 8'h5A);
        chk("t2_cfg_new", cfg[15:8], 8'hA5);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("t2_valid_drop", data_valid, 1'b0);

        // T3: read-only protection
        status_in = 16'h3CC3;
        cyc(1'b1, 1'b0, 4'd8, 8'hFF, 8'h00);
        chk("t3_wr_error", wr_error, 1'b1);
        cyc(1'b0, 1'b1, 4'd8, 8'h00, 8'h00);
        chk("t3_wr_error_drop", wr_error, 1'b0);
        chk("t3_rd", data_out, 8'hC3);

        // T4: coherent snapshot
        status_in = 16'h1234;
        cyc(1'b0, 1'b1, 4'd8, 8'h00, 8'h00);
        chk("t4_rd8a", data_out, 8'h34);
        status_in = 16'h5678;
        cyc(1'b0, 1'b1, 4'd9, 8'h00, 8'h00);
        chk("t4_rd9a", data_out, 8'h12);
        cyc(1'b0, 1'b1, 4'd8, 8'h00, 8'h00);
        chk("t4_rd8b", data_out, 8'h78);
        cyc(1'b0, 1'b1, 4'd9, 8'h00, 8'h00);
        chk("t4_rd9b", data_out, 8'h56);

        // T5: W1C sticky
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01);
        chk("t5_set", cfg[87:80], 8'h01);
        cyc(1'b1, 1'b0, 4'd10, 8'h01, 8'h00);
        chk("t5_clear", cfg[87:80], 8'h00);
        cyc(1'b1, 1'b0, 4'd10, 8'h01, 8'h01);
        chk("t5_set_wins", cfg[87:80], 8'h01);

        // T6: masked irq (mask = 0, sticky bit0 set)
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h01);
        chk("t6_masked", irq, 1'b0);
        cyc(1'b1, 1'b0, 4'd11, 8'h01, 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("t6_irq_on", irq, 1'b1);
        cyc(1'b1, 1'b0, 4'd10, 8'h01, 8'h00);
        chk("t6_sticky_clr", cfg[87:80], 8'h00);
        cyc(1'b0, 1'b0, 4'd0, 8'h00, 8'h00);
        chk("t6_irq_off", irq, 1'b0);

        // Randomized traffic with occasional async resets
        for (int n = 0; n < 800; n++) begin
            logic [7:0] ev;
            ev = ($urandom_range(0, 5) == 0) ? (8'h01 << $urandom_range(0, 7)) : 8'h00;
            if ($urandom_range(0, 3) == 0) status_in = 16'($urandom);
            rstn = ($urandom_range(0, 99) != 0);
            if (!rstn) begin
                #1;
                model_reset();
                compare_all();
            end
            cyc(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                4'($urandom_range(0, 15)), 8'($urandom), ev);
        end
        rstn = 1'b1;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
